tdc_uart_feeder: RTL
====================

Name: tdc_uart_feeder

Overview:
- Sits directly upstream of the UART framer, which sends one 16-bit word as three bytes: header 123, high byte, low byte.
- Buffers 16-bit TDC measurement results in a FIFO.
- Presents one result at a time as data[15:0] with a held data_rdy pulse.
- Enforces a minimum frame spacing so the framer is never re-triggered mid-frame.
- Reports queue occupancy and overflow to the control/debug logic.

Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 words (16).
- PULSE_LEN, 4, number of cycles data_rdy is held high per word (legal range 2..15).
- FRAME_GAP, 12000, cycles from data_rdy falling to earliest next launch (3 bytes × 10 bits × 400 clk/bit).

Ports:
- clk_20m  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  16  TDC result word.
- in_valid  in  1  single-cycle strobe: in_data is valid this cycle.
- clear  in  1  synchronous flush of queue and flags.
- tx_busy  in  1  framer/transmitter busy level; no launch while high.
- data  out  16  word presented to the framer.
- data_rdy  out  1  framer start strobe, high for PULSE_LEN cycles.
- count  out  DEPTH_LOG2+1  words currently queued.
- overflow  out  1  sticky: a word was dropped.
- drop_cnt  out  8  dropped-word counter, saturates at 255.

Behaviour:
- Reset (rst_n=0, asynchronous) values:
  - data=16'd32000, data_rdy=0, count=0, overflow=0, drop_cnt=0.
  - FSM=IDLE; read/write pointers=0; gap counter=0.
- FIFO write:
  - When in_valid=1, the word is accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped: overflow<=1 and drop_cnt<=drop_cnt+1 (saturating at 255).
- Pointers: wrap modulo DEPTH. count = writes − pops, never exceeds DEPTH, never underflows.
- FSM states:
  - IDLE:
    - Launch when count>0 and tx_busy=0.
    - On launch, in the same clock: pop the head word, register it into data, data_rdy<=1, go to PULSE.
    - Zero-latency flow: a word written while IDLE with an empty FIFO launches on the next cycle (2 cycles from in_valid to data_rdy=1).
  - PULSE:
    - data_rdy held high for exactly PULSE_LEN cycles; data held stable throughout.
    - Then data_rdy<=0, gap counter<=0, go to GAP.
  - GAP:
    - Gap counter increments each cycle.
    - At FRAME_GAP−1, go to IDLE.
    - data keeps its last value until the next launch and is never changed while data_rdy=1.
- Minimum launch-to-launch spacing: PULSE_LEN+FRAME_GAP+1 cycles. It is longer if tx_busy is still high in IDLE.
- Simultaneous events:
  - Write and pop in the same cycle with the FIFO full: the write is accepted, count is unchanged, no overflow.
  - Write and pop with count=1: the popped word is the old head; the new word remains queued; count stays 1.
- clear=1:
  - Empties the FIFO (pointers=0, count=0) and zeroes overflow and drop_cnt.
  - Does not abort PULSE/GAP; the word in flight completes normally.
  - An in_valid in the same cycle as clear is discarded and not counted as a drop.
- Reset mid-operation: data_rdy drops asynchronously to 0; all queued words are lost; no partial pulse resumes after reset release.
- Reads from an empty FIFO are impossible by construction: launch requires count>0.

Test Plan:
- Basic launch (PULSE_LEN=4, FRAME_GAP=20): reset, then in_valid with in_data=16'h1234 once → data=16'h1234 and data_rdy high for cycles 2..5 after the strobe; count returns to 0; next launch is not possible before 25 cycles later.
- Burst (FRAME_GAP=20): 3 back-to-back in_valid with words 16'h0001, 16'h0002, 16'h0003 → three data_rdy pulses in order, launch-to-launch spacing = 25 cycles; count goes 1, 2, then back down to 0.
- Overflow: with tx_busy=1, write 18 words → count=16, overflow=1, drop_cnt=2. Release tx_busy → the first 16 words emerge in order; the words with indices 16 and 17 never appear.
- Full + simultaneous: FIFO full, in_valid coincides with a launch → count stays 16, overflow stays 0, and the new word is emitted last.
- clear during GAP: 5 words queued, assert clear during GAP → current pulse already done, count=0, overflow=0, drop_cnt=0, no further data_rdy.
- Async reset during PULSE: rst_n low in the 2nd pulse cycle → data_rdy=0 immediately and data=16'd32000. After release, with no new input, data_rdy stays 0 for 100 cycles.

Source files
------------

// File: rtl/tdc_uart_feeder.sv
// ----------------------------------------------------------------------------
// tdc_uart_feeder
//   Buffers 16-bit TDC results in a small FIFO. Words are handed to the UART
//   framer one at a time. Launches are spaced so that the framer is never
//   restarted while it is still sending a three-byte frame.
//
// Ports
//   clk_20m   in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_data   in   [15:0] TDC result word
//   in_valid  in   single-cycle strobe for in_data
//   clear     in   synchronous flush of the queue and the overflow flags
//   tx_busy   in   framer busy level; no launch while high
//   data      out  [15:0] word presented to the framer
//   data_rdy  out  framer start strobe, high for PULSE_LEN cycles
//   count     out  [DEPTH_LOG2:0] words currently queued
//   overflow  out  sticky flag: a word was dropped
//   drop_cnt  out  [7:0] dropped-word counter, saturates at 255
// ----------------------------------------------------------------------------
module tdc_uart_feeder #(
   parameter int DEPTH_LOG2 = 4,
   parameter int PULSE_LEN  = 4,      // 2..15
   parameter int FRAME_GAP  = 12000   // 3 bytes x 10 bits x 400 clk/bit
) (
   input  logic                  clk_20m,
   input  logic                  rst_n,
   input  logic [15:0]           in_data,
   input  logic                  in_valid,
   input  logic                  clear,
   input  logic                  tx_busy,
   output logic [15:0]           data,
   output logic                  data_rdy,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic [7:0]            drop_cnt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int GAP_W = (FRAME_GAP > 2) ? $clog2(FRAME_GAP) : 1;

   localparam logic [DEPTH_LOG2:0] L_DEPTH      = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [3:0]          L_PULSE_LAST = 4'(PULSE_LEN - 1);
   localparam logic [GAP_W-1:0]    L_GAP_LAST   = GAP_W'(FRAME_GAP - 1);

   typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

   state_t                r_state;
   logic [3:0]            r_pcnt;
   logic [GAP_W-1:0]      r_gcnt;
   logic [15:0]           r_data;
   logic                  r_rdy;
   logic [15:0]           r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  r_ovf;
   logic [7:0]            r_drop;

   logic w_full;
   logic w_launch;
   logic w_push;
   logic w_drop;

   assign w_full   = (r_count == L_DEPTH);
   // A flush takes priority over a launch: the queue is being emptied.
   assign w_launch = (r_state == S_IDLE) && (r_count != '0) && !tx_busy && !clear;
   // A launch frees a slot in the same cycle, so a full FIFO still accepts.
   assign w_push   = in_valid && !clear && (!w_full || w_launch);
   assign w_drop   = in_valid && !clear && w_full && !w_launch;

   // Storage has no reset; occupancy is tracked by the pointers/count.
   always_ff @(posedge clk_20m) begin
      if (w_push) r_mem[r_wr_ptr] <= in_data;
   end

   always_ff @(posedge clk_20m or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_pcnt   <= '0;
         r_gcnt   <= '0;
         r_data   <= 16'd32000;
         r_rdy    <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_drop   <= '0;
      end else begin
         // Queue bookkeeping
         if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_drop   <= '0;
         end else begin
            if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_launch) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_launch})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: ;
            endcase
            if (w_drop) begin
               r_ovf <= 1'b1;
               if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
            end
         end

         // Launch sequencer; clear does not abort a frame in flight
         case (r_state)
            S_IDLE: begin
               if (w_launch) begin
                  r_data  <= r_mem[r_rd_ptr];
                  r_rdy   <= 1'b1;
                  r_pcnt  <= '0;
                  r_state <= S_PULSE;
               end
            end
            S_PULSE: begin
               if (r_pcnt == L_PULSE_LAST) begin
                  r_rdy   <= 1'b0;
                  r_gcnt  <= '0;
                  r_state <= S_GAP;
               end else begin
                  r_pcnt <= r_pcnt + 4'd1;
               end
            end
            S_GAP: begin
               if (r_gcnt == L_GAP_LAST) r_state <= S_IDLE;
               else                      r_gcnt  <= r_gcnt + 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign data     = r_data;
   assign data_rdy = r_rdy;
   assign count    = r_count;
   assign overflow = r_ovf;
   assign drop_cnt = r_drop;

endmodule
